// File: rtl/iir_mac_sched_pkg.sv
// Shared types and constants for the IIR MAC sequencer.
package iir_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEN,
    S_SUMA,
    S_NUM,
    S_OUT,
    S_SHIFT
  } sched_state_t;

  localparam int DEN_TAPS   = 4;
  localparam int NUM_TAPS   = 5;
  localparam int CYC_PER_CH = 12;

  // Taps whose product is subtracted rather than added
  localparam logic [4:0] SUB_MASK = 5'b01010;

  function automatic logic tap_is_sub(input logic [2:0] tap);
    logic [7:0] mask_ext;
    mask_ext = {3'b000, SUB_MASK};
    return mask_ext[tap];
  endfunction

endpackage

// File: rtl/iir_mac_sched_if.sv
// Control/config bundle between the sequencer (master) and the MAC datapath (slave).
interface iir_mac_sched_if #(
  parameter int CHW = 2,
  parameter int BW  = 2
);
  logic           f_s;
  logic           en;
  logic           cfg_bank_req;
  logic [BW-1:0]  cfg_bank_sel;
  logic           ovr_clr;
  logic [CHW-1:0] ch_sel;
  logic [2:0]     tap_sel;
  logic           num_sel;
  logic           mac_clr;
  logic           mac_en;
  logic           mac_sub;
  logic           suma_we;
  logic           dout_we;
  logic           sr_shift;
  logic [BW-1:0]  bank_act;
  logic           busy;
  logic           frame_done;
  logic           overrun;
  logic           ovr_flag;

  modport master (
    input  f_s, en, cfg_bank_req, cfg_bank_sel, ovr_clr,
    output ch_sel, tap_sel, num_sel, mac_clr, mac_en, mac_sub, suma_we,
           dout_we, sr_shift, bank_act, busy, frame_done, overrun, ovr_flag
  );

  modport slave (
    output f_s, en, cfg_bank_req, cfg_bank_sel, ovr_clr,
    input  ch_sel, tap_sel, num_sel, mac_clr, mac_en, mac_sub, suma_we,
           dout_we, sr_shift, bank_act, busy, frame_done, overrun, ovr_flag
  );
endinterface

// File: rtl/iir_mac_sched_fs_sync_edge.sv
// Two-flop synchronizer for the sample strobe plus a registered rising-edge pulse.
module fs_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_out
);
  logic sync_ff1;
  logic sync_ff2;
  logic prev;

  // Synchronize, remember the previous level, and register the edge pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
      prev     <= 1'b0;
      rise_out <= 1'b0;
    end else begin
      sync_ff1 <= async_in;
      sync_ff2 <= sync_ff1;
      prev     <= sync_ff2;
      rise_out <= sync_ff2 & ~prev;
    end
  end
endmodule

// File: rtl/iir_mac_sched.sv
// Frame sequencer for a shared DF-II biquad-pair MAC: steps every channel through
// denominator taps, sum_a write, numerator taps, output write and delay-line shift.
// Bank changes are deferred to frame start; strobes arriving mid-frame are flagged.
module iir_mac_sched
  import iir_sched_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CHW   = 2,
  parameter int BANKS = 4,
  parameter int BW    = 2
) (
  input logic            clk,
  input logic            rst,
  iir_mac_sched_if.master bus
);
  localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);

  sched_state_t   state;
  logic           fs_rise;
  logic [CHW-1:0] ch;
  logic [2:0]     tap;
  logic           num_sel;
  logic           mac_clr;
  logic           mac_en;
  logic           mac_sub;
  logic           suma_we;
  logic           dout_we;
  logic           sr_shift;
  logic [BW-1:0]  bank_act;
  logic [BW-1:0]  bank_pend;
  logic           pend_valid;
  logic           busy;
  logic           frame_done;
  logic           overrun;
  logic           ovr_flag;
  logic           req_ok;

  fs_sync_edge u_fs_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.f_s),
    .rise_out (fs_rise)
  );

  // Requests naming a bank that does not exist are dropped
  assign req_ok = bus.cfg_bank_req && (int'(bus.cfg_bank_sel) < BANKS);

  // Sequencer FSM with registered control strobes, bank staging and overrun tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ch         <= '0;
      tap        <= '0;
      num_sel    <= 1'b0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      mac_sub    <= 1'b0;
      suma_we    <= 1'b0;
      dout_we    <= 1'b0;
      sr_shift   <= 1'b0;
      bank_act   <= '0;
      bank_pend  <= '0;
      pend_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      ovr_flag   <= 1'b0;
    end else begin
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      mac_sub    <= 1'b0;
      suma_we    <= 1'b0;
      dout_we    <= 1'b0;
      sr_shift   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= fs_rise && (state != S_IDLE);
      ovr_flag   <= (fs_rise && (state != S_IDLE)) || (ovr_flag && !bus.ovr_clr);

      case (state)
        S_IDLE: begin
          if (fs_rise && bus.en) begin
            state   <= S_DEN;
            ch      <= '0;
            tap     <= 3'd1;
            num_sel <= 1'b0;
            mac_en  <= 1'b1;
            mac_clr <= 1'b1;
            mac_sub <= tap_is_sub(3'd1);
            busy    <= 1'b1;
            if (pend_valid) bank_act <= bank_pend;
            pend_valid <= 1'b0;
          end
        end
        S_DEN: begin
          if (tap == 3'(DEN_TAPS)) begin
            state   <= S_SUMA;
            suma_we <= 1'b1;
          end else begin
            tap     <= tap + 3'd1;
            mac_en  <= 1'b1;
            mac_sub <= tap_is_sub(tap + 3'd1);
          end
        end
        S_SUMA: begin
          state   <= S_NUM;
          tap     <= 3'd0;
          num_sel <= 1'b1;
          mac_en  <= 1'b1;
          mac_clr <= 1'b1;
          mac_sub <= tap_is_sub(3'd0);
        end
        S_NUM: begin
          if (tap == 3'(NUM_TAPS - 1)) begin
            state   <= S_OUT;
            dout_we <= 1'b1;
          end else begin
            tap     <= tap + 3'd1;
            mac_en  <= 1'b1;
            mac_sub <= tap_is_sub(tap + 3'd1);
          end
        end
        S_OUT: begin
          state      <= S_SHIFT;
          sr_shift   <= 1'b1;
          frame_done <= (ch == LAST_CH);
        end
        S_SHIFT: begin
          if (ch == LAST_CH) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= S_DEN;
            ch      <= ch + CHW'(1);
            tap     <= 3'd1;
            num_sel <= 1'b0;
            mac_en  <= 1'b1;
            mac_clr <= 1'b1;
            mac_sub <= tap_is_sub(3'd1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A request in the frame-start cycle is staged for the following frame
      if (req_ok) begin
        bank_pend  <= bus.cfg_bank_sel;
        pend_valid <= 1'b1;
      end
    end
  end

  assign bus.ch_sel     = ch;
  assign bus.tap_sel    = tap;
  assign bus.num_sel    = num_sel;
  assign bus.mac_clr    = mac_clr;
  assign bus.mac_en     = mac_en;
  assign bus.mac_sub    = mac_sub;
  assign bus.suma_we    = suma_we;
  assign bus.dout_we    = dout_we;
  assign bus.sr_shift   = sr_shift;
  assign bus.bank_act   = bank_act;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
  assign bus.overrun    = overrun;
  assign bus.ovr_flag   = ovr_flag;
endmodule

// File: tb/tb_iir_mac_sched.sv
// Bench for iir_mac_sched: every cycle is compared against a frame-offset model.
module tb_iir_mac_sched;
  import iir_sched_pkg::*;

  localparam int CH    = 4;
  localparam int CHW   = 2;
  localparam int BANKS = 4;
  localparam int BW    = 2;
  localparam int FRAME = CYC_PER_CH * CH;
  localparam int VW    = CHW + 3 + 1 + 6 + BW + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #50 clk = ~clk;

  iir_mac_sched_if #(.CHW(CHW), .BW(BW)) bus ();

  iir_mac_sched #(.CH(CH), .CHW(CHW), .BANKS(BANKS), .BW(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int busy_cnt, fd_cnt, ovr_cnt;

  // reference model state: mk = offset into frame, -1 when idle
  int mk, m_bank, m_pend, m_pend_v, m_flag, h_ch, h_tap, h_num;
  bit fsh [5];
  logic [VW-1:0] m_exp;

  typedef struct {int busy; int mac_en; int tap; int clr; int sub;} lat_t;
  typedef struct {int nreq; int sel_a; int sel_b; int exp_bank;} bank_t;
  lat_t  lat  [5];
  bank_t bnk  [4];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t (model offset %0d)", name, act, exp, $time, mk);
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {bus.ch_sel, bus.tap_sel, bus.num_sel, bus.mac_clr, bus.mac_en, bus.mac_sub,
            bus.suma_we, bus.dout_we, bus.sr_shift, bus.bank_act, bus.busy,
            bus.frame_done, bus.overrun, bus.ovr_flag};
  endfunction

  task automatic model_clear();
    mk = -1; m_bank = 0; m_pend = 0; m_pend_v = 0; m_flag = 0;
    h_ch = 0; h_tap = 0; h_num = 0;
    for (int i = 0; i < 5; i++) fsh[i] = 1'b0;
    m_exp = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    bit evt, was_busy, start, ovr;
    int j, en_c, clr, sub, suma, dout, shf, fd;
    if (!rst) begin
      model_clear();
      return;
    end
    for (int i = 4; i > 0; i--) fsh[i] = fsh[i-1];
    fsh[0] = bus.f_s;
    // strobe seen 3 edges through the synchronizer, acted on one edge later
    evt      = fsh[3] && !fsh[4];
    was_busy = (mk >= 0);
    ovr      = evt && was_busy;
    m_flag   = (ovr || (m_flag != 0 && !bus.ovr_clr)) ? 1 : 0;
    start    = !was_busy && evt && bus.en;
    if (start) begin
      if (m_pend_v != 0) m_bank = m_pend;
      m_pend_v = 0;
    end
    if (bus.cfg_bank_req) begin
      m_pend = int'(bus.cfg_bank_sel);
      m_pend_v = 1;
    end
    if (was_busy) mk = (mk == FRAME - 1) ? -1 : mk + 1;
    else if (start) mk = 0;

    en_c = 0; clr = 0; sub = 0; suma = 0; dout = 0; shf = 0; fd = 0;
    if (mk >= 0) begin
      h_ch = mk / CYC_PER_CH;
      j    = mk % CYC_PER_CH;
      if (j < DEN_TAPS) begin
        h_tap = j + 1; h_num = 0; en_c = 1; clr = (j == 0);
      end else if (j == DEN_TAPS) begin
        suma = 1;
      end else if (j < DEN_TAPS + 1 + NUM_TAPS) begin
        h_tap = j - DEN_TAPS - 1; h_num = 1; en_c = 1; clr = (h_tap == 0);
      end else if (j == DEN_TAPS + 1 + NUM_TAPS) begin
        dout = 1;
      end else begin
        shf = 1; fd = (h_ch == CH - 1);
      end
      if (en_c != 0) sub = (h_tap == 1 || h_tap == 3);
    end
    m_exp = {CHW'(h_ch), 3'(h_tap), 1'(h_num), 1'(clr), 1'(en_c), 1'(sub),
             1'(suma), 1'(dout), 1'(shf), BW'(m_bank), 1'(mk >= 0), 1'(fd),
             1'(ovr), 1'(m_flag)};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_vec("cycle", dut_vec(), m_exp);
    busy_cnt += int'(bus.busy);
    fd_cnt   += int'(bus.frame_done);
    ovr_cnt  += int'(bus.overrun);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic pulse_fs(int hi);
    bus.f_s = 1'b1;
    run(hi);
    bus.f_s = 1'b0;
  endtask

  task automatic clr_counts();
    busy_cnt = 0; fd_cnt = 0; ovr_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    lat[0] = '{0, 0, 0, 0, 0};
    lat[1] = '{0, 0, 0, 0, 0};
    lat[2] = '{0, 0, 0, 0, 0};
    lat[3] = '{1, 1, 1, 1, 1};
    lat[4] = '{1, 1, 2, 0, 0};
    bnk[0] = '{1, 2, 0, 2};
    bnk[1] = '{2, 1, 3, 3};
    bnk[2] = '{2, 3, 0, 0};
    bnk[3] = '{0, 0, 0, 0};

    bus.f_s = 1'b0; bus.en = 1'b1; bus.cfg_bank_req = 1'b0;
    bus.cfg_bank_sel = '0; bus.ovr_clr = 1'b0;
    model_clear();
    clr_counts();

    // reset state
    @(negedge clk);
    run(3);
    check("reset_outputs", int'(dut_vec()), 0);
    rst = 1'b1;
    run(3);

    // latency and one full frame
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      bus.f_s = (i < 3);
      step();
      check("lat_busy", int'(bus.busy), lat[i].busy);
      check("lat_mac_en", int'(bus.mac_en), lat[i].mac_en);
      check("lat_tap", int'(bus.tap_sel), lat[i].tap);
      check("lat_clr", int'(bus.mac_clr), lat[i].clr);
      check("lat_sub", int'(bus.mac_sub), lat[i].sub);
    end
    run(52);
    check("frame_busy_len", busy_cnt, FRAME);
    check("frame_done_cnt", fd_cnt, 1);
    check("frame_no_ovr", ovr_cnt, 0);

    // overrun: second strobe 30 cycles into the frame
    clr_counts();
    pulse_fs(3);
    run(27);
    pulse_fs(3);
    run(40);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_flag_set", int'(bus.ovr_flag), 1);
    check("ovr_busy_len", busy_cnt, FRAME);
    check("ovr_frame_done", fd_cnt, 1);
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    check("ovr_flag_clr", int'(bus.ovr_flag), 0);

    // set and clear in the same cycle
    pulse_fs(3);
    run(10);
    pulse_fs(3);
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    check("ovr_same_pulse", int'(bus.overrun), 1);
    check("ovr_set_wins", int'(bus.ovr_flag), 1);
    run(45);
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;

    // bank requests while idle
    for (int r = 0; r < 4; r++) begin
      for (int q = 0; q < bnk[r].nreq; q++) begin
        bus.cfg_bank_req = 1'b1;
        bus.cfg_bank_sel = BW'((q == 0) ? bnk[r].sel_a : bnk[r].sel_b);
        step();
        bus.cfg_bank_req = 1'b0;
        step();
      end
      pulse_fs(3);
      step();
      check("bank_table", int'(bus.bank_act), bnk[r].exp_bank);
      run(50);
    end

    // bank request mid-frame is deferred
    pulse_fs(3);
    run(10);
    bus.cfg_bank_req = 1'b1;
    bus.cfg_bank_sel = BW'(2);
    step();
    bus.cfg_bank_req = 1'b0;
    run(40);
    check("bank_hold", int'(bus.bank_act), 0);
    run(5);
    pulse_fs(3);
    step();
    check("bank_next", int'(bus.bank_act), 2);
    run(50);

    // en dropped mid-frame
    clr_counts();
    pulse_fs(3);
    run(5);
    bus.en = 1'b0;
    run(50);
    check("en_off_done", fd_cnt, 1);
    check("en_off_busy", busy_cnt, FRAME);
    clr_counts();
    pulse_fs(3);
    run(20);
    check("en_off_ignored", busy_cnt, 0);
    check("en_off_no_ovr", ovr_cnt, 0);
    bus.en = 1'b1;

    // reset mid-frame
    pulse_fs(3);
    run(17);
    rst = 1'b0;
    #1;
    model_clear();
    check("rst_async", int'(dut_vec()), 0);
    run(2);
    rst = 1'b1;
    run(2);
    clr_counts();
    pulse_fs(3);
    step();
    check("rst_ch0", int'(bus.ch_sel), 0);
    check("rst_tap1", int'(bus.tap_sel), 1);
    run(50);
    check("rst_frame_done", fd_cnt, 1);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) bus.f_s = ~bus.f_s;
      bus.en           = ($urandom_range(0, 9) != 0);
      bus.cfg_bank_req = ($urandom_range(0, 15) == 0);
      bus.cfg_bank_sel = BW'($urandom);
      bus.ovr_clr      = ($urandom_range(0, 19) == 0);
      step();
    end
    bus.f_s = 1'b0; bus.cfg_bank_req = 1'b0; bus.ovr_clr = 1'b0;
    run(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
